ws2812_refresh_ctrl: RTL and testbench
======================================

Name: ws2812_refresh_ctrl

Overview:
- Sequences delivery of the 384-bit LED framebuffer (16 pixels x 24 bits) to a WS2812 chain over a single-wire output.
- Snapshots the framebuffer on request, serialises it with WS2812 bit timing, then holds the line low for the latch period.
- Sits between the timer/animation logic that owns the framebuffer and the LED data pin.
- Coalesces refresh requests that arrive while a frame is in flight.

Parameters:
- NUM_PIXELS, 16, pixels in chain; framebuf width = 24*NUM_PIXELS.
- T0H, 20, clk cycles dout high for a 0 bit.
- T1H, 40, clk cycles dout high for a 1 bit.
- TBIT, 62, total clk cycles per bit; must satisfy T1H < TBIT.
- TRESET, 2600, clk cycles dout held low after the last bit (latch).
- BRIGHT_SHIFT, 2, right-shift applied per channel when BRIGHTNESS_LIMIT_EN is defined.

Ports:
- clk  in  1  system clock; the timing parameters are in units of this clock.
- nrst  in  1  asynchronous active-low reset.
- framebuf  in  24*NUM_PIXELS  pixel data; pixel i occupies [24i+23:24i], with G=[24i+7:24i], R=[24i+15:24i+8], B=[24i+23:24i+16].
- refresh_req  in  1  request a frame send; level or pulse, sampled each cycle.
- busy  out  1  high while a frame is loading, sending or latching.
- frame_done  out  1  one-cycle pulse when the latch period ends.
- dout  out  1  WS2812 serial data.

Behaviour:
- Reset (asynchronous, nrst=0):
  - dout=0, busy=0, frame_done=0.
  - State IDLE; pending flag cleared; shift register cleared.
  - A reset mid-frame aborts the frame immediately. dout drops low in the same instant; no partial-frame completion.
- States: IDLE, LOAD, SEND, LATCH.
- IDLE:
  - If refresh_req or pending is set, go to LOAD next cycle, set busy, clear pending.
- LOAD, one cycle:
  - Copy framebuf into the internal shift register. The snapshot is taken here; later framebuf changes do not affect this frame.
  - Reset the bit and pixel counters; go to SEND.
- SEND:
  - Bit period counter runs 0..TBIT-1.
  - dout=1 while count < (bit ? T1H : T0H), else 0.
  - Transmit order: pixel 0 first. Within a pixel: G byte, then R byte, then B byte. Each byte MSB first.
  - Total bits = 24*NUM_PIXELS. The first bit's high phase begins the cycle after LOAD.
  - After the last bit's TBIT cycles, go to LATCH.
- LATCH:
  - dout=0 for exactly TRESET cycles.
  - On the final cycle, pulse frame_done and drop busy the following cycle.
  - Next state: LOAD if pending, else IDLE.
- Coalescing:
  - refresh_req seen in LOAD/SEND/LATCH sets pending (single-depth). Any number of requests yields at most one further frame.
  - refresh_req coincident with the LATCH final cycle is also captured as pending.
- Back-to-back frames: with pending set, LOAD follows LATCH with no IDLE cycle. busy stays high; frame_done still pulses once per frame.
- Counter widths: $clog2 of TBIT, TRESET and 24*NUM_PIXELS respectively. Counters never wrap mid-state.

Optional Feature:
- Macro: BRIGHTNESS_LIMIT_EN.
- Defined: in LOAD, each 8-bit channel is stored as channel >> BRIGHT_SHIFT, zero-filled. Example: 0xFF becomes 0x3F with BRIGHT_SHIFT=2. Timing is unchanged.
- Undefined: channels are transmitted unmodified; BRIGHT_SHIFT is unused.

Decomposition:
- Shared package (ws2812_pkg):
  - state enum {IDLE, LOAD, SEND, LATCH};
  - default timing constants T0H/T1H/TBIT/TRESET;
  - BITS_PER_PIXEL=24 and channel byte offsets G=0, R=8, B=16.
- One natural sub-module, ws2812_bit_encoder: takes bit_valid/bit_value, produces dout and bit_done using the TBIT counter.
- The controller keeps the FSM, snapshot, byte reordering and pending logic.

Test Plan:
- Reset: assert nrst=0 mid-SEND. dout=0 and busy=0 immediately; no frame_done. After release, state is IDLE.
- All-zero frame, one refresh_req pulse:
  - busy rises the next cycle.
  - 384 bits, each 20 cycles high and 42 low.
  - Then 2600 low cycles, a frame_done pulse, and busy=0.
- framebuf pixel0 G=0xA5, rest 0: the first 8 bit high-times are 40,20,40,20,20,40,20,40 cycles; all later bits are 20.
- Snapshot: change framebuf during SEND. The serialised stream still matches the LOAD-time value.
- Coalescing: three refresh_req pulses during SEND of frame 1.
  - Exactly one extra frame, starting LOAD directly after LATCH.
  - busy stays high throughout; two frame_done pulses total.
- BRIGHTNESS_LIMIT_EN defined, pixel0 B=0xFF: the B byte is sent as 0x3F, i.e. bits 0,0,1,1,1,1,1,1.

Source files
------------

// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared states, timing defaults and pixel layout for the WS2812 refresh path
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SEND  = 2'd2,
    LATCH = 2'd3
  } state_t;

  localparam int DEF_T0H    = 20;
  localparam int DEF_T1H    = 40;
  localparam int DEF_TBIT   = 62;
  localparam int DEF_TRESET = 2600;

  localparam int BITS_PER_PIXEL = 24;
  localparam int G_OFS          = 0;
  localparam int R_OFS          = 8;
  localparam int B_OFS          = 16;

endpackage

// File: rtl/ws2812_bit_encoder.sv
// rtl/ws2812_bit_encoder.sv - shapes one WS2812 bit period from bit_valid/bit_value
module ws2812_bit_encoder #(
  parameter int T0H  = 20,
  parameter int T1H  = 40,
  parameter int TBIT = 62
) (
  input  logic clk,
  input  logic nrst,
  input  logic bit_valid,
  input  logic bit_value,
  output logic dout,
  output logic bit_done
);

  localparam int CW = $clog2(TBIT);

  logic [CW-1:0] cnt;

  // The period counter idles at zero so a new bit always starts with its high phase.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (!bit_valid || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_done = bit_valid && (cnt == CW'(TBIT - 1));
  assign dout     = bit_valid && (cnt < (bit_value ? CW'(T1H) : CW'(T0H)));

endmodule

// File: rtl/ws2812_refresh_ctrl.sv
// rtl/ws2812_refresh_ctrl.sv - framebuffer snapshot, serialisation and latch sequencing for a WS2812 chain
// Optional BRIGHTNESS_LIMIT_EN: each channel is right-shifted by BRIGHT_SHIFT at snapshot time.
module ws2812_refresh_ctrl
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS   = 16,
  parameter int T0H          = DEF_T0H,
  parameter int T1H          = DEF_T1H,
  parameter int TBIT         = DEF_TBIT,
  parameter int TRESET       = DEF_TRESET,
  parameter int BRIGHT_SHIFT = 2
) (
  input  logic                               clk,
  input  logic                               nrst,
  input  logic [BITS_PER_PIXEL*NUM_PIXELS-1:0] framebuf,
  input  logic                               refresh_req,
  output logic                               busy,
  output logic                               frame_done,
  output logic                               dout
);

  localparam int TOTAL_BITS = BITS_PER_PIXEL * NUM_PIXELS;
  localparam int BW         = $clog2(TOTAL_BITS);
  localparam int LW         = $clog2(TRESET);

`ifdef BRIGHTNESS_LIMIT_EN
  localparam bit BRIGHT_EN = 1'b1;
`else
  localparam bit BRIGHT_EN = 1'b0;
`endif

  state_t                  state, state_nx;
  logic                    pending, pending_nx;
  logic [TOTAL_BITS-1:0]   shreg;
  logic [TOTAL_BITS-1:0]   load_vec;
  logic [BW-1:0]           bit_idx;
  logic [LW-1:0]           latch_cnt;
  logic                    bit_done;
  logic                    last_bit;
  logic                    latch_last;

  function automatic logic [7:0] scale(input logic [7:0] ch);
    return BRIGHT_EN ? (ch >> BRIGHT_SHIFT) : ch;
  endfunction

  // Reorder into wire order so the shift register just streams out its MSB:
  // pixel 0 at the top, each pixel as G,R,B with every byte MSB first.
  for (genvar p = 0; p < NUM_PIXELS; p++) begin : g_pix
    assign load_vec[TOTAL_BITS-1-p*BITS_PER_PIXEL -: BITS_PER_PIXEL] = {
      scale(framebuf[p*BITS_PER_PIXEL+G_OFS +: 8]),
      scale(framebuf[p*BITS_PER_PIXEL+R_OFS +: 8]),
      scale(framebuf[p*BITS_PER_PIXEL+B_OFS +: 8])
    };
  end

  assign last_bit   = (bit_idx == BW'(TOTAL_BITS - 1));
  assign latch_last = (latch_cnt == LW'(TRESET - 1));
  assign busy       = (state != IDLE);

  ws2812_bit_encoder #(
    .T0H  (T0H),
    .T1H  (T1H),
    .TBIT (TBIT)
  ) u_enc (
    .clk       (clk),
    .nrst      (nrst),
    .bit_valid (state == SEND),
    .bit_value (shreg[TOTAL_BITS-1]),
    .dout      (dout),
    .bit_done  (bit_done)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      shreg     <= '0;
      bit_idx   <= '0;
      latch_cnt <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      case (state)
        LOAD: begin
          shreg     <= load_vec;
          bit_idx   <= '0;
          latch_cnt <= '0;
        end
        SEND: begin
          if (bit_done && !last_bit) begin
            shreg   <= shreg << 1;
            bit_idx <= bit_idx + 1'b1;
          end
        end
        LATCH: begin
          latch_cnt <= latch_last ? '0 : latch_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Requests during a frame collapse into one pending flag; one arriving on the
  // final latch cycle still earns a follow-on frame without an IDLE gap.
  always_comb begin
    state_nx   = state;
    pending_nx = pending;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (refresh_req || pending) begin
          state_nx   = LOAD;
          pending_nx = 1'b0;
        end
      end
      LOAD: begin
        state_nx = SEND;
        if (refresh_req) pending_nx = 1'b1;
      end
      SEND: begin
        if (refresh_req) pending_nx = 1'b1;
        if (bit_done && last_bit) state_nx = LATCH;
      end
      LATCH: begin
        if (refresh_req) pending_nx = 1'b1;
        if (latch_last) begin
          frame_done = 1'b1;
          state_nx   = (pending || refresh_req) ? LOAD : IDLE;
          pending_nx = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ws2812_refresh_ctrl.sv
// tb/tb_ws2812_refresh_ctrl.sv - directed self-checking bench for ws2812_refresh_ctrl
module tb_ws2812_refresh_ctrl;

  localparam int TOTAL  = 384;
  localparam int TBIT   = 62;
  localparam int TRESET = 2600;

  logic             clk = 1'b0;
  logic             nrst;
  logic [TOTAL-1:0] framebuf;
  logic             refresh_req;
  logic             busy;
  logic             frame_done;
  logic             dout;

  int total = 0;
  int bad   = 0;

  int   hi [TOTAL];
  int   shape_bad, latch_hi, early_done, busy_low;
  logic done_last, load_ok;
  logic [TOTAL-1:0] fb_new;

  ws2812_refresh_ctrl dut (
    .clk         (clk),
    .nrst        (nrst),
    .framebuf    (framebuf),
    .refresh_req (refresh_req),
    .busy        (busy),
    .frame_done  (frame_done),
    .dout        (dout)
  );

  always #5 clk = ~clk;

  // Called at the negedge where LOAD is expected; ends at the final latch cycle.
  task automatic capture_frame(input logic do_inject);
    logic prev;
    load_ok    = (busy === 1'b1) && (dout === 1'b0);
    shape_bad  = 0;
    latch_hi   = 0;
    early_done = 0;
    busy_low   = 0;
    done_last  = 1'b0;
    for (int b = 0; b < TOTAL; b++) begin
      hi[b] = 0;
      prev  = 1'b1;
      for (int t = 0; t < TBIT; t++) begin
        @(negedge clk);
        if (dout === 1'b1) begin
          hi[b]++;
          if (!prev) shape_bad++;
        end else if (dout !== 1'b0) begin
          shape_bad++;
        end
        prev = (dout === 1'b1);
        if (frame_done !== 1'b0) early_done++;
        if (busy !== 1'b1) busy_low++;
        refresh_req = do_inject && (t == 0) && (b == 2 || b == 100 || b == 300);
        if (do_inject && b == 20 && t == 0) framebuf = fb_new;
      end
    end
    for (int t = 0; t < TRESET; t++) begin
      @(negedge clk);
      if (dout !== 1'b0) latch_hi++;
      if (busy !== 1'b1) busy_low++;
      if (t == TRESET - 1) done_last = (frame_done === 1'b1);
      else if (frame_done !== 1'b0) early_done++;
    end
  endtask

  task automatic check_frame_shape(input string tag);
    total++;
    if (load_ok !== 1'b1) begin bad++; $display("FAIL %s_load: busy=%b dout=%b, required busy=1 dout=0", tag, busy, dout); end
    total++;
    if (shape_bad !== 0) begin bad++; $display("FAIL %s_shape: %0d broken bit periods, required 0", tag, shape_bad); end
    total++;
    if (latch_hi !== 0) begin bad++; $display("FAIL %s_latch_low: %0d high cycles in latch, required 0", tag, latch_hi); end
    total++;
    if (early_done !== 0) begin bad++; $display("FAIL %s_early_done: %0d stray frame_done, required 0", tag, early_done); end
    total++;
    if (done_last !== 1'b1) begin bad++; $display("FAIL %s_done_pulse: got %b, required 1", tag, done_last); end
    total++;
    if (busy_low !== 0) begin bad++; $display("FAIL %s_busy_held: %0d low cycles, required 0", tag, busy_low); end
  endtask

  task automatic test_reset();
    int viol;
    nrst        = 1'b0;
    refresh_req = 1'b0;
    framebuf    = '0;
    fb_new      = '0;
    @(negedge clk);
    total++;
    if ({dout, busy, frame_done} !== 3'b000) begin
      bad++; $display("FAIL reset_outputs: dout/busy/done=%b, required 000", {dout, busy, frame_done});
    end
    nrst = 1'b1;
    @(negedge clk);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (dout !== 1'b1) begin bad++; $display("FAIL reset_pre_high: dout=%b, required 1", dout); end
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    #2 nrst = 1'b0;
    #1;
    total++;
    if ({dout, busy, frame_done} !== 3'b000) begin
      bad++; $display("FAIL reset_abort: dout/busy/done=%b, required 000", {dout, busy, frame_done});
    end
    @(negedge clk);
    nrst = 1'b1;
    viol = 0;
    repeat (20) begin
      @(negedge clk);
      if ({dout, busy, frame_done} !== 3'b000) viol++;
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL reset_idle: %0d active cycles after reset, required 0", viol); end
  endtask

  task automatic test_all_zero();
    int nm;
    framebuf = '0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL zero_busy_before: got %b, required 0", busy); end
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL zero_busy_rise: got %b, required 1", busy); end
    capture_frame(1'b0);
    check_frame_shape("zero");
    nm = 0;
    for (int k = 0; k < TOTAL; k++) if (hi[k] !== 20) nm++;
    total++;
    if (nm !== 0) begin bad++; $display("FAIL zero_high_times: %0d bits not 20 cycles high (bit0=%0d), required 0", nm, hi[0]); end
    @(negedge clk);
    total++;
    if ({busy, frame_done} !== 2'b00) begin bad++; $display("FAIL zero_end: busy/done=%b, required 00", {busy, frame_done}); end
  endtask

  task automatic test_pattern_snapshot();
    int nm;
    int exp_hi [8];
`ifdef BRIGHTNESS_LIMIT_EN
    exp_hi = '{20, 20, 40, 20, 40, 20, 20, 40};
`else
    exp_hi = '{40, 20, 40, 20, 20, 40, 20, 40};
`endif
    framebuf       = '0;
    framebuf[7:0]  = 8'hA5;
    fb_new         = '0;
    fb_new[7:0]    = 8'h3C;
    fb_new[23:16]  = 8'hFF;
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    capture_frame(1'b1);
    check_frame_shape("pat");
    for (int k = 0; k < 8; k++) begin
      total++;
      if (hi[k] !== exp_hi[k]) begin bad++; $display("FAIL pat_bit%0d: high=%0d, required %0d", k, hi[k], exp_hi[k]); end
    end
    nm = 0;
    for (int k = 8; k < TOTAL; k++) if (hi[k] !== 20) nm++;
    total++;
    if (nm !== 0) begin bad++; $display("FAIL pat_snapshot: %0d later bits not 20 cycles high, required 0", nm); end
  endtask

  task automatic test_back_to_back();
    int nm, viol;
    int exp;
    logic [7:0] c_g, c_b;
`ifdef BRIGHTNESS_LIMIT_EN
    c_g = 8'h0F;
    c_b = 8'h3F;
`else
    c_g = 8'h3C;
    c_b = 8'hFF;
`endif
    @(negedge clk);
    total++;
    if ({busy, dout} !== 2'b10) begin bad++; $display("FAIL b2b_load_direct: busy/dout=%b, required 10", {busy, dout}); end
    capture_frame(1'b0);
    check_frame_shape("b2b");
    nm = 0;
    for (int k = 0; k < TOTAL; k++) begin
      if (k < 8) exp = c_g[7-k] ? 40 : 20;
      else if (k >= 16 && k < 24) exp = c_b[23-k] ? 40 : 20;
      else exp = 20;
      if (hi[k] !== exp) nm++;
    end
    total++;
    if (nm !== 0) begin bad++; $display("FAIL b2b_stream: %0d bits wrong (bit16 high=%0d), required 0", nm, hi[16]); end
    viol = 0;
    repeat (30) begin
      @(negedge clk);
      if ({busy, dout, frame_done} !== 3'b000) viol++;
    end
    total++;
    if (viol !== 0) begin bad++; $display("FAIL b2b_single_extra: %0d active cycles after second frame, required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_pattern_snapshot();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
